id_operand_resolver: RTL and testbench
======================================

// Module: id_operand_resolver
// PURPOSE
//   ID-stage consumer of the bypass bus. Owns the 32x32 register file and resolves both
//   source operands from four places, in priority order: EXE, MEM, WB, then the RF.
//   Raises the data-hazard interlock (id_ready_go=0) when the youngest producer has no
//   final data yet. Captures resolved operands while EXE back-pressures ID, so a producer
//   that retires during the stall cannot corrupt them.
// PARAMETERS
//   ADDR_W   5    register address width
//   DATA_W   32   data width
//   NREG     32   register count; r0 hard-wired to zero
//   CNT_W    16   hazard-stall counter width
//   STG_W    ADDR_W+DATA_W+2 (39); one stage slice of the bus
// PORTS
//   clk              in   1      core clock
//   reset            in   1      synchronous, active-high
//   BY_to_ID_bus     in   3*STG_W (117)  {EXE,MEM,WB} slices
//                                 each slice = {w_addr[4:0], w_data[31:0], data_valid, rf_w_en}; EXE in MSBs
//   id_valid         in   1      ID holds a live instruction
//   id_src1_addr     in   ADDR_W source 1 register
//   id_src1_use      in   1      instruction reads source 1
//   id_src2_addr     in   ADDR_W source 2 register
//   id_src2_use      in   1      instruction reads source 2
//   exe_allowin      in   1      EXE can accept this cycle
//   flush            in   1      kill ID contents (branch/exception)
//   id_src1_data     out  DATA_W resolved operand 1
//   id_src2_data     out  DATA_W resolved operand 2
//   id_ready_go      out  1      operands complete; ID may issue
//   hazard_stall_cnt out  CNT_W  saturating count of interlock cycles
// BEHAVIOUR
//   Reset (sync):
//     - all RF entries, hold registers, hold-valid bits and hazard_stall_cnt go to 0.
//     - Outputs after reset: data=0, id_ready_go=1 when no source is in use.
//   Stage match for source s:
//     - rf_w_en=1, w_addr==s_addr and s_addr!=0.
//     - The highest-priority matching stage wins (EXE > MEM > WB).
//     - If the winning stage has data_valid=0, source s is not ready. This covers loads
//       in EXE and unreturned loads in MEM.
//     - A lower stage is never used to bypass an unready higher stage.
//   Resolution:
//     - No stage match: operand = RF[s_addr]. Address 0 reads as 0 regardless of stage
//       or RF contents.
//     - Unused sources (use=0) are always ready; their data value is don't-care but
//       driven deterministically.
//   Interlock:
//     - id_ready_go = !(used source not ready). This output is combinational, with
//       zero-cycle latency.
//     - Fire = id_valid & id_ready_go & exe_allowin.
//   Operand hold:
//     - When the cycle is id_valid & !flush & !exe_allowin and source s is ready with
//       hold_valid_s=0, capture the resolved value into hold_s and set hold_valid_s.
//     - While hold_valid_s=1, id_src_s_data = hold_s and source s counts as ready.
//     - Hold-valid bits clear on fire or flush. Flush has priority over capture in the
//       same cycle.
//   RF write:
//     - RF[WB.w_addr] <= WB.w_data at posedge when WB.rf_w_en & WB.data_valid and
//       w_addr!=0.
//     - Same-cycle read of that register returns the WB value via the bypass path, not
//       the stale RF value. There is no write-then-read bubble.
//   Stall counter:
//     - Increments when id_valid & !id_ready_go & !flush.
//     - Saturates at 2^CNT_W-1 and never wraps.
//   Reset mid-stall: all state clears and the interlock is re-evaluated from the inputs.
// STRUCTURE
//   Shared package / header:
//     - STG_W, BY_TO_ID_BUS_WD and the slice field offsets; the bus layout is shared
//       with the bypass producer.
//     - ADDR_W and DATA_W.
//   Sub-module regfile_2r1w (NREG x DATA_W):
//     - 2 asynchronous read ports, 1 synchronous write port, r0 forced zero, sync reset clear.
//   Remaining logic lives in the top module:
//     - per-source match/priority mux, written as a function or generate over 2 sources
//     - hold registers
//     - stall counter
// TESTING
//   1. RAW on ALU result: EXE slice {addr=5, data=0x1234, valid=1, we=1}; src1=5, use=1
//      -> src1_data=0x1234, ready_go=1 in the same cycle.
//   2. Load-use: EXE {addr=7, valid=0, we=1} and MEM {addr=7, data=0xAA, valid=1}; src2=7
//      -> ready_go=0 and cnt increments. Next cycle MEM {7, 0xBEEF, valid=1}
//      -> src2=0xBEEF, ready_go=1.
//   3. r0: src1=0 with EXE {addr=0, data=0xFFFF_FFFF, we=1} -> src1_data=0, ready_go=1.
//   4. Hold: src1=3 resolved from WB (0x55), exe_allowin=0 for 3 cycles while WB retires
//      and RF[3] is overwritten by a later WB with 0x66 -> output stays 0x55 until fire.
//      Repeat with flush -> hold clears.
//   5. WB write plus same-cycle read: WB {addr=9, 0x77, valid=1}, src1=9 -> src1=0x77;
//      next cycle with no match -> RF read gives 0x77.
//   6. Counter saturation: preset stall for 2^16+5 cycles -> cnt=0xFFFF. Then assert
//      reset for 1 cycle -> cnt=0, RF reads 0.

Source files
------------

// File: rtl/id_operand_resolver_pkg.sv
// Shared bypass-bus layout between the bypass producer and the ID-stage operand resolver.
// Each stage slice is {w_addr, w_data, data_valid, rf_w_en}; EXE sits in the MSBs, WB in the LSBs.
package id_operand_resolver_pkg;

  localparam int ADDR_W          = 5;
  localparam int DATA_W          = 32;
  localparam int STG_W           = ADDR_W + DATA_W + 2;
  localparam int BY_TO_ID_BUS_WD = 3 * STG_W;

  // Field offsets inside one stage slice
  localparam int RF_W_EN_OFF    = 0;
  localparam int DATA_VALID_OFF = 1;
  localparam int W_DATA_OFF     = 2;
  localparam int W_ADDR_OFF     = W_DATA_OFF + DATA_W;

  // Slice offsets inside the bus
  localparam int WB_OFF  = 0;
  localparam int MEM_OFF = STG_W;
  localparam int EXE_OFF = 2 * STG_W;

  typedef struct packed {
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_data;
    logic              data_valid;
    logic              rf_w_en;
  } byp_stg_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              ready;
  } opnd_t;

  function automatic byp_stg_t get_stg(input logic [BY_TO_ID_BUS_WD-1:0] bus, input int off);
    byp_stg_t s;
    s.w_addr     = bus[off + W_ADDR_OFF +: ADDR_W];
    s.w_data     = bus[off + W_DATA_OFF +: DATA_W];
    s.data_valid = bus[off + DATA_VALID_OFF];
    s.rf_w_en    = bus[off + RF_W_EN_OFF];
    return s;
  endfunction

endpackage

// File: rtl/regfile_2r1w.sv
// Register file: two asynchronous read ports, one synchronous write port, r0 reads as zero.
// Reads are zero-latency; writes land at the clock edge; no backpressure.
module regfile_2r1w #(
  parameter int NREG   = 32,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] raddr0,
  output logic [DATA_W-1:0] rdata0,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata
);

  logic [DATA_W-1:0] mem [NREG];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) mem[i] <= '0;
    end else if (we && (waddr != '0)) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata0 = (raddr0 == '0) ? '0 : mem[raddr0];
  assign rdata1 = (raddr1 == '0) ? '0 : mem[raddr1];

endmodule

// File: rtl/id_operand_resolver.sv
// ID-stage operand resolver: EXE > MEM > WB > RF bypass with load-use interlock and operand hold.
// Operands and id_ready_go are combinational (zero latency); resolved values are held while EXE stalls ID.
module id_operand_resolver
  import id_operand_resolver_pkg::*;
#(
  parameter int NREG  = 32,
  parameter int CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [BY_TO_ID_BUS_WD-1:0] BY_to_ID_bus,
  input  logic                       id_valid,
  input  logic [ADDR_W-1:0]          id_src1_addr,
  input  logic                       id_src1_use,
  input  logic [ADDR_W-1:0]          id_src2_addr,
  input  logic                       id_src2_use,
  input  logic                       exe_allowin,
  input  logic                       flush,
  output logic [DATA_W-1:0]          id_src1_data,
  output logic [DATA_W-1:0]          id_src2_data,
  output logic                       id_ready_go,
  output logic [CNT_W-1:0]           hazard_stall_cnt
);

  byp_stg_t exe_stg, mem_stg, wb_stg;
  assign exe_stg = get_stg(BY_to_ID_bus, EXE_OFF);
  assign mem_stg = get_stg(BY_to_ID_bus, MEM_OFF);
  assign wb_stg  = get_stg(BY_to_ID_bus, WB_OFF);

  logic [1:0][ADDR_W-1:0] src_addr;
  logic [1:0]             src_use;
  logic [1:0][DATA_W-1:0] rf_rdata;
  logic [1:0][DATA_W-1:0] src_data;
  logic [1:0]             src_ready;
  logic                   fire;

  assign src_addr = {id_src2_addr, id_src1_addr};
  assign src_use  = {id_src2_use, id_src1_use};

  regfile_2r1w #(
    .NREG   (NREG),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_rf (
    .clk    (clk),
    .reset  (reset),
    .raddr0 (id_src1_addr),
    .rdata0 (rf_rdata[0]),
    .raddr1 (id_src2_addr),
    .rdata1 (rf_rdata[1]),
    .we     (wb_stg.rf_w_en & wb_stg.data_valid),
    .waddr  (wb_stg.w_addr),
    .wdata  (wb_stg.w_data)
  );

  // The youngest matching producer decides; an unready one is never bypassed by an older stage.
  function automatic opnd_t resolve(input byp_stg_t exe, input byp_stg_t mem, input byp_stg_t wb,
                                    input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] rf_data);
    opnd_t r;
    r.data  = rf_data;
    r.ready = 1'b1;
    if (addr == '0) begin
      r.data = '0;
    end else if (exe.rf_w_en && (exe.w_addr == addr)) begin
      r.data  = exe.w_data;
      r.ready = exe.data_valid;
    end else if (mem.rf_w_en && (mem.w_addr == addr)) begin
      r.data  = mem.w_data;
      r.ready = mem.data_valid;
    end else if (wb.rf_w_en && (wb.w_addr == addr)) begin
      r.data  = wb.w_data;
      r.ready = wb.data_valid;
    end
    return r;
  endfunction

  for (genvar s = 0; s < 2; s++) begin : g_src
    opnd_t             res;
    logic              hold_vld_q;
    logic [DATA_W-1:0] hold_q;
    logic              capture;

    always_comb res = resolve(exe_stg, mem_stg, wb_stg, src_addr[s], rf_rdata[s]);

    assign src_ready[s] = hold_vld_q | ~src_use[s] | res.ready;
    assign src_data[s]  = hold_vld_q ? hold_q : res.data;
    assign capture      = id_valid & ~flush & ~exe_allowin & ~hold_vld_q & (~src_use[s] | res.ready);

    always_ff @(posedge clk) begin
      if (reset) begin
        hold_vld_q <= 1'b0;
        hold_q     <= '0;
      end else if (flush || fire) begin
        hold_vld_q <= 1'b0;
      end else if (capture) begin
        hold_vld_q <= 1'b1;
        hold_q     <= res.data;
      end
    end
  end

  assign id_ready_go  = &src_ready;
  assign fire         = id_valid & id_ready_go & exe_allowin;
  assign id_src1_data = src_data[0];
  assign id_src2_data = src_data[1];

  always_ff @(posedge clk) begin
    if (reset) begin
      hazard_stall_cnt <= '0;
    end else if (id_valid && !id_ready_go && !flush && (hazard_stall_cnt != {CNT_W{1'b1}})) begin
      hazard_stall_cnt <= hazard_stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_id_operand_resolver.sv
// Scoreboard bench for id_operand_resolver: each step pushes its expected outputs, the negedge sample pops them.
module tb_id_operand_resolver;
  import id_operand_resolver_pkg::*;

  logic                       clk = 1'b0;
  logic                       reset;
  logic [BY_TO_ID_BUS_WD-1:0] by_bus;
  logic                       id_valid;
  logic [ADDR_W-1:0]          id_src1_addr, id_src2_addr;
  logic                       id_src1_use, id_src2_use;
  logic                       exe_allowin, flush;
  logic [DATA_W-1:0]          id_src1_data, id_src2_data;
  logic                       id_ready_go;
  logic [15:0]                hazard_stall_cnt;

  always #5 clk = ~clk;

  id_operand_resolver dut (
    .clk              (clk),
    .reset            (reset),
    .BY_to_ID_bus     (by_bus),
    .id_valid         (id_valid),
    .id_src1_addr     (id_src1_addr),
    .id_src1_use      (id_src1_use),
    .id_src2_addr     (id_src2_addr),
    .id_src2_use      (id_src2_use),
    .exe_allowin      (exe_allowin),
    .flush            (flush),
    .id_src1_data     (id_src1_data),
    .id_src2_data     (id_src2_data),
    .id_ready_go      (id_ready_go),
    .hazard_stall_cnt (hazard_stall_cnt)
  );

  typedef struct packed {
    logic [STG_W-1:0] exe, mem, wb;
    logic [4:0]       s1;
    logic             u1;
    logic [4:0]       s2;
    logic             u2;
    logic             vld, allow, fl;
    logic [31:0]      d1;
    logic             c1;
    logic [31:0]      d2;
    logic             c2;
    logic             rg;
  } step_t;

  typedef struct packed {
    logic [80:0] val;
    logic [80:0] mask;
  } exp_t;

  localparam logic [STG_W-1:0] NONE = '0;

  exp_t        sb_q[$];
  step_t       st[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [15:0] cnt_model;

  function automatic logic [STG_W-1:0] slc(input logic [4:0] a, input logic [31:0] d, input logic v, input logic w);
    return {a, d, v, w};
  endfunction

  function automatic exp_t exp_of(input step_t s, input logic [15:0] c);
    exp_t e;
    e.val  = {s.d1, s.d2, s.rg, c};
    e.mask = {{32{s.c1}}, {32{s.c2}}, 1'b1, 16'hFFFF};
    return e;
  endfunction

  function automatic logic [80:0] obs();
    return {id_src1_data, id_src2_data, id_ready_go, hazard_stall_cnt};
  endfunction

  task automatic apply(input step_t s);
    by_bus       = {s.exe, s.mem, s.wb};
    id_src1_addr = s.s1;
    id_src1_use  = s.u1;
    id_src2_addr = s.s2;
    id_src2_use  = s.u2;
    id_valid     = s.vld;
    exe_allowin  = s.allow;
    flush        = s.fl;
  endtask

  task automatic test_reset();
    step_t s;
    exp_t  e;
    s = '0;
    s.s1 = 5'd1; s.u1 = 1'b1; s.s2 = 5'd2; s.u2 = 1'b1;
    s.c1 = 1'b1; s.c2 = 1'b1; s.rg = 1'b1;
    reset = 1'b1;
    apply(s);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    cnt_model = 16'h0;
    sb_q.push_back(exp_of(s, cnt_model));
    @(negedge clk);
    e = sb_q.pop_front();
    n_cmp++;
    if ((obs() & e.mask) !== (e.val & e.mask)) begin
      n_bad++;
      $display("FAIL reset: got %h required %h", obs() & e.mask, e.val & e.mask);
    end
  endtask

  task automatic test_bypass();
    exp_t e;
    st.delete();
    st.push_back('{slc(5'd5,32'h1234,1'b1,1'b1), NONE, NONE, 5'd5,1'b1, 5'd0,1'b0, 1'b1,1'b1,1'b0, 32'h1234,1'b1, 32'h0,1'b0, 1'b1});
    st.push_back('{slc(5'd4,32'hE,1'b1,1'b1), slc(5'd4,32'hF,1'b1,1'b1), slc(5'd4,32'h10,1'b1,1'b1), 5'd0,1'b0, 5'd4,1'b1, 1'b1,1'b1,1'b0, 32'h0,1'b0, 32'hE,1'b1, 1'b1});
    st.push_back('{NONE, slc(5'd4,32'hF,1'b1,1'b1), slc(5'd4,32'h20,1'b1,1'b1), 5'd4,1'b1, 5'd4,1'b1, 1'b1,1'b1,1'b0, 32'hF,1'b1, 32'hF,1'b1, 1'b1});
    st.push_back('{NONE, NONE, NONE, 5'd4,1'b1, 5'd0,1'b0, 1'b1,1'b1,1'b0, 32'h20,1'b1, 32'h0,1'b0, 1'b1});
    st.push_back('{slc(5'd0,32'hFFFF_FFFF,1'b1,1'b1), NONE, NONE, 5'd0,1'b1, 5'd0,1'b0, 1'b1,1'b1,1'b0, 32'h0,1'b1, 32'h0,1'b0, 1'b1});
    st.push_back('{slc(5'd0,32'h0,1'b0,1'b1), NONE, slc(5'd0,32'hDEAD,1'b1,1'b1), 5'd0,1'b1, 5'd0,1'b1, 1'b1,1'b1,1'b0, 32'h0,1'b1, 32'h0,1'b1, 1'b1});
    st.push_back('{NONE, NONE, slc(5'd9,32'h77,1'b1,1'b1), 5'd9,1'b1, 5'd0,1'b0, 1'b1,1'b1,1'b0, 32'h77,1'b1, 32'h0,1'b0, 1'b1});
    st.push_back('{NONE, NONE, NONE, 5'd9,1'b1, 5'd9,1'b1, 1'b1,1'b1,1'b0, 32'h77,1'b1, 32'h77,1'b1, 1'b1});
    st.push_back('{NONE, NONE, NONE, 5'd0,1'b1, 5'd0,1'b0, 1'b1,1'b1,1'b0, 32'h0,1'b1, 32'h0,1'b0, 1'b1});
    st.push_back('{slc(5'd9,32'h99,1'b1,1'b0), NONE, NONE, 5'd9,1'b1, 5'd0,1'b0, 1'b1,1'b1,1'b0, 32'h77,1'b1, 32'h0,1'b0, 1'b1});
    foreach (st[i]) begin
      @(posedge clk); #1;
      apply(st[i]);
      sb_q.push_back(exp_of(st[i], cnt_model));
      @(negedge clk);
      e = sb_q.pop_front();
      n_cmp++;
      if ((obs() & e.mask) !== (e.val & e.mask)) begin
        n_bad++;
        $display("FAIL bypass step %0d: got %h required %h", i, obs() & e.mask, e.val & e.mask);
      end
      if (st[i].vld && !st[i].rg && !st[i].fl && cnt_model != 16'hFFFF) cnt_model++;
    end
    apply('0);
  endtask

  task automatic test_load_use();
    exp_t e;
    st.delete();
    st.push_back('{slc(5'd7,32'h0,1'b0,1'b1), slc(5'd7,32'hAA,1'b1,1'b1), NONE, 5'd0,1'b0, 5'd7,1'b1, 1'b1,1'b1,1'b0, 32'h0,1'b0, 32'h0,1'b0, 1'b0});
    st.push_back('{NONE, slc(5'd7,32'hBEEF,1'b1,1'b1), NONE, 5'd0,1'b0, 5'd7,1'b1, 1'b1,1'b1,1'b0, 32'h0,1'b0, 32'hBEEF,1'b1, 1'b1});
    st.push_back('{NONE, slc(5'd7,32'h0,1'b0,1'b1), slc(5'd7,32'h1,1'b1,1'b1), 5'd0,1'b0, 5'd7,1'b1, 1'b1,1'b1,1'b0, 32'h0,1'b0, 32'h0,1'b0, 1'b0});
    st.push_back('{slc(5'd6,32'h0,1'b0,1'b1), NONE, NONE, 5'd7,1'b1, 5'd6,1'b0, 1'b1,1'b1,1'b0, 32'h1,1'b1, 32'h0,1'b0, 1'b1});
    st.push_back('{slc(5'd7,32'h0,1'b0,1'b1), NONE, NONE, 5'd7,1'b1, 5'd0,1'b0, 1'b0,1'b1,1'b0, 32'h0,1'b0, 32'h0,1'b0, 1'b0});
    st.push_back('{slc(5'd7,32'h0,1'b0,1'b1), NONE, NONE, 5'd7,1'b1, 5'd0,1'b0, 1'b1,1'b1,1'b1, 32'h0,1'b0, 32'h0,1'b0, 1'b0});
    st.push_back('{NONE, NONE, NONE, 5'd7,1'b1, 5'd0,1'b0, 1'b1,1'b1,1'b0, 32'h1,1'b1, 32'h0,1'b0, 1'b1});
    foreach (st[i]) begin
      @(posedge clk); #1;
      apply(st[i]);
      sb_q.push_back(exp_of(st[i], cnt_model));
      @(negedge clk);
      e = sb_q.pop_front();
      n_cmp++;
      if ((obs() & e.mask) !== (e.val & e.mask)) begin
        n_bad++;
        $display("FAIL load_use step %0d: got %h required %h", i, obs() & e.mask, e.val & e.mask);
      end
      if (st[i].vld && !st[i].rg && !st[i].fl && cnt_model != 16'hFFFF) cnt_model++;
    end
    apply('0);
  endtask

  task automatic test_hold();
    exp_t e;
    st.delete();
    st.push_back('{NONE, NONE, slc(5'd3,32'h55,1'b1,1'b1), 5'd3,1'b1, 5'd3,1'b1, 1'b1,1'b0,1'b0, 32'h55,1'b1, 32'h55,1'b1, 1'b1});
    st.push_back('{NONE, NONE, slc(5'd3,32'h66,1'b1,1'b1), 5'd3,1'b1, 5'd3,1'b1, 1'b1,1'b0,1'b0, 32'h55,1'b1, 32'h55,1'b1, 1'b1});
    st.push_back('{slc(5'd3,32'h0,1'b0,1'b1), NONE, NONE, 5'd3,1'b1, 5'd3,1'b1, 1'b1,1'b0,1'b0, 32'h55,1'b1, 32'h55,1'b1, 1'b1});
    st.push_back('{NONE, NONE, NONE, 5'd3,1'b1, 5'd3,1'b1, 1'b1,1'b1,1'b0, 32'h55,1'b1, 32'h55,1'b1, 1'b1});
    st.push_back('{NONE, NONE, NONE, 5'd3,1'b1, 5'd0,1'b0, 1'b1,1'b1,1'b0, 32'h66,1'b1, 32'h0,1'b0, 1'b1});
    st.push_back('{NONE, NONE, slc(5'd3,32'h11,1'b1,1'b1), 5'd3,1'b1, 5'd0,1'b0, 1'b1,1'b0,1'b0, 32'h11,1'b1, 32'h0,1'b0, 1'b1});
    st.push_back('{NONE, NONE, slc(5'd3,32'h22,1'b1,1'b1), 5'd3,1'b1, 5'd0,1'b0, 1'b1,1'b0,1'b1, 32'h11,1'b1, 32'h0,1'b0, 1'b1});
    st.push_back('{NONE, NONE, NONE, 5'd3,1'b1, 5'd0,1'b0, 1'b1,1'b0,1'b0, 32'h22,1'b1, 32'h0,1'b0, 1'b1});
    st.push_back('{slc(5'd3,32'h33,1'b1,1'b1), NONE, slc(5'd3,32'h44,1'b1,1'b1), 5'd3,1'b1, 5'd0,1'b0, 1'b1,1'b1,1'b0, 32'h22,1'b1, 32'h0,1'b0, 1'b1});
    st.push_back('{NONE, NONE, NONE, 5'd3,1'b1, 5'd0,1'b0, 1'b1,1'b1,1'b0, 32'h44,1'b1, 32'h0,1'b0, 1'b1});
    foreach (st[i]) begin
      @(posedge clk); #1;
      apply(st[i]);
      sb_q.push_back(exp_of(st[i], cnt_model));
      @(negedge clk);
      e = sb_q.pop_front();
      n_cmp++;
      if ((obs() & e.mask) !== (e.val & e.mask)) begin
        n_bad++;
        $display("FAIL hold step %0d: got %h required %h", i, obs() & e.mask, e.val & e.mask);
      end
      if (st[i].vld && !st[i].rg && !st[i].fl && cnt_model != 16'hFFFF) cnt_model++;
    end
    apply('0);
  endtask

  task automatic test_saturation();
    step_t s;
    exp_t  e;
    s = '{slc(5'd8,32'h0,1'b0,1'b1), NONE, NONE, 5'd8,1'b1, 5'd9,1'b1, 1'b1,1'b1,1'b0, 32'h0,1'b0, 32'h77,1'b1, 1'b0};
    @(posedge clk); #1;
    apply(s);
    repeat (65541) @(posedge clk);
    cnt_model = 16'hFFFF;
    sb_q.push_back(exp_of(s, cnt_model));
    @(negedge clk);
    e = sb_q.pop_front();
    n_cmp++;
    if ((obs() & e.mask) !== (e.val & e.mask)) begin
      n_bad++;
      $display("FAIL saturate: got %h required %h", obs() & e.mask, e.val & e.mask);
    end
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    s.d2 = 32'h0;
    cnt_model = 16'h0;
    sb_q.push_back(exp_of(s, cnt_model));
    @(negedge clk);
    e = sb_q.pop_front();
    n_cmp++;
    if ((obs() & e.mask) !== (e.val & e.mask)) begin
      n_bad++;
      $display("FAIL reset_mid_stall: got %h required %h", obs() & e.mask, e.val & e.mask);
    end
    cnt_model = 16'h1;
    sb_q.push_back(exp_of(s, cnt_model));
    @(negedge clk);
    e = sb_q.pop_front();
    n_cmp++;
    if ((obs() & e.mask) !== (e.val & e.mask)) begin
      n_bad++;
      $display("FAIL stall_after_reset: got %h required %h", obs() & e.mask, e.val & e.mask);
    end
    apply('0);
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_load_use();
    test_hold();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
